// File: rtl/psg_write_sequencer.sv
// -----------------------------------------------------------------------------
// psg_write_sequencer
//
// Host-facing write port for the PSG register file. Control bytes arrive over
// a valid/ready handshake and are buffered in a small FIFO. Each byte is then
// replayed to the register file as a single-cycle write strobe. Consecutive
// strobes are spaced at least WRITE_GAP cycles apart, which emulates the
// chip's write time. Byte contents are passed through without interpretation.
//
// Parameters:
//   DATA_BITS   width of a control byte
//   FIFO_DEPTH  FIFO entries (power of two, >= 2)
//   WRITE_GAP   minimum cycles between out_write strobes (>= 1)
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   in_data        host control byte
//   in_valid       host offers in_data this cycle
//   in_ready       FIFO can accept a byte this cycle
//   out_data       byte presented to the register file
//   out_write      one-cycle strobe: register file applies out_data
//   busy           FIFO non-empty, gap timer running, or strobe in flight
//   fifo_level     current FIFO occupancy (0..FIFO_DEPTH)
//   overflow_clear clears the sticky overflow flag
//   overflow       sticky dropped-byte flag
//
// Optional feature macro: PSG_OVERFLOW_FLAG_EN
//   Defined   : overflow is set on every dropped byte and cleared by
//               overflow_clear; a drop in the same cycle wins.
//   Undefined : overflow is tied to 0 and overflow_clear is ignored.
// -----------------------------------------------------------------------------
module psg_write_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WRITE_GAP  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_write,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          overflow_clear,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  // The gap counter only has to hold WRITE_GAP-1.
  localparam int GAP_W = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 push;
  logic                 pop;

  // Readiness comes from the registered level only, so a full FIFO never
  // accepts in the same cycle it pops (no bypass path).
  assign in_ready   = (level < LVL_W'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign pop        = (gap_cnt == '0) && (level != '0);
  assign fifo_level = level;
  assign busy       = (level != '0) | (gap_cnt != '0) | out_write;

  // NOTE: the storage array has no reset; only pointers and level define what
  // is valid, and leaving the array unreset lets it map onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      gap_cnt   <= '0;
      out_data  <= '0;
      out_write <= 1'b0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_data  <= mem[rd_ptr];
        out_write <= 1'b1;
        gap_cnt   <= GAP_W'(WRITE_GAP - 1);
      end else begin
        out_write <= 1'b0;
        if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
      end

      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef PSG_OVERFLOW_FLAG_EN
  logic overflow_q;

  // A drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow_q <= 1'b1;
    end else if (overflow_clear) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_overflow_clear;

  assign unused_overflow_clear = overflow_clear;
  assign overflow              = 1'b0;
`endif

endmodule

// File: tb/tb_psg_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_psg_write_sequencer
//
// Two instances share one stimulus: dut_slow (WRITE_GAP=32) and dut_fast
// (WRITE_GAP=1); `sel` chooses which one is compared. The reference model is
// a byte queue plus the edge index of the last strobe: a pop is allowed when
// at least WRITE_GAP edges have passed since the previous one.
// -----------------------------------------------------------------------------
module tb_psg_write_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       overflow_clear;

  logic       ready_s, write_s, busy_s, ovf_s;
  logic [7:0] data_s;
  logic [2:0] level_s;
  logic       ready_f, write_f, busy_f, ovf_f;
  logic [7:0] data_f;
  logic [2:0] level_f;

  psg_write_sequencer #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .WRITE_GAP(32)) dut_slow (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_s), .out_data(data_s), .out_write(write_s), .busy(busy_s),
    .fifo_level(level_s), .overflow_clear(overflow_clear), .overflow(ovf_s)
  );

  psg_write_sequencer #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .WRITE_GAP(1)) dut_fast (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_f), .out_data(data_f), .out_write(write_f), .busy(busy_f),
    .fifo_level(level_f), .overflow_clear(overflow_clear), .overflow(ovf_f)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit sel      = 1'b0;   // 0: dut_slow, 1: dut_fast

  // Reference model state
  logic [7:0] q[$];
  int         cyc      = 0;
  int         last     = 0;
  bit         has_last = 1'b0;
  logic [7:0] m_data   = 8'h00;
  bit         m_write  = 1'b0;
  bit         m_ovf    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d, sel %0d)", tag, obs, exp, cyc, sel);
    end
  endtask

  // One clock cycle: drive inputs, check readiness, advance model and DUT,
  // then check the registered outputs #1 after the edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit clr, input bit rst);
    int  gap;
    bit  rdy;
    bit  pop;
    bit  exp_busy;
    bit  exp_ovf;
    gap            = sel ? 1 : 32;
    in_valid       = v;
    in_data        = d;
    overflow_clear = clr;
    reset          = rst;
    rdy            = (q.size() < DEPTH);
    check("in_ready", {31'd0, sel ? ready_f : ready_s}, {31'd0, rdy});

    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      has_last = 1'b0;
      m_data   = 8'h00;
      m_write  = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      pop     = (q.size() > 0) && (!has_last || (cyc - last >= gap));
      m_write = pop;
      if (pop) begin
        m_data   = q.pop_front();
        last     = cyc;
        has_last = 1'b1;
      end
      if (v && rdy) q.push_back(d);
      if (v && !rdy)  m_ovf = 1'b1;
      else if (clr)   m_ovf = 1'b0;
    end
    #1;
    // Busy while bytes wait, the strobe is up, or the gap counter is nonzero
    // (it reads WRITE_GAP-1-(edges since strobe) until it reaches zero).
    exp_busy = (q.size() != 0) || (has_last && ((cyc == last) || (cyc - last < gap - 1)));
`ifdef PSG_OVERFLOW_FLAG_EN
    exp_ovf = m_ovf;
`else
    exp_ovf = 1'b0;
`endif
    check("out_write",  {31'd0, sel ? write_f : write_s}, {31'd0, m_write});
    check("out_data",   {24'd0, sel ? data_f : data_s},   {24'd0, m_data});
    check("fifo_level", {29'd0, sel ? level_f : level_s}, q.size());
    check("busy",       {31'd0, sel ? busy_f : busy_s},   {31'd0, exp_busy});
    check("overflow",   {31'd0, sel ? ovf_f : ovf_s},     {31'd0, exp_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] burst [4];
  int         strobes;

  initial begin
    burst[0] = 8'h8A; burst[1] = 8'h06; burst[2] = 8'h9F; burst[3] = 8'hE4;

    // Power-on reset and reset-state checks on both instances.
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; overflow_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready_s", {31'd0, ready_s}, 32'd1);
    check("rst_write_s", {31'd0, write_s}, 32'd0);
    check("rst_data_s",  {24'd0, data_s},  32'd0);
    check("rst_level_s", {29'd0, level_s}, 32'd0);
    check("rst_busy_s",  {31'd0, busy_s},  32'd0);
    check("rst_ovf_s",   {31'd0, ovf_s},   32'd0);
    check("rst_ready_f", {31'd0, ready_f}, 32'd1);
    check("rst_level_f", {29'd0, level_f}, 32'd0);

    // Single write: strobe one cycle after acceptance, busy ends 32 later.
    cycle(1'b1, 8'h8A, 1'b0, 1'b0);
    idle(40);

    // Back-to-back burst of four bytes, strobes 32 cycles apart.
    strobes = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, burst[i], 1'b0, 1'b0);
    for (int i = 0; i < 4 * 32 + 4; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (write_s) strobes++;
    end
    check("burst_strobes", strobes, 32'd3);  // first strobe fell inside the push loop

    // Overfill: six consecutive pushes, the sixth is dropped.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);          // clear pulse
    idle(4 * 32 + 4);

    // Drop and clear in the same cycle: the drop wins.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h2F, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-burst: nothing buffered may come out afterwards.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(40);

    // Randomised traffic on the WRITE_GAP=32 instance.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 199) == 0));
    end

    // Switch to WRITE_GAP=1: both instances reset on the same edge.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    sel = 1'b1;

    // Streaming: eight bytes with continuous valid, eight consecutive strobes.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    idle(4);

    // Randomised traffic on the WRITE_GAP=1 instance.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 149) == 0));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
